box_stream_arbiter: RTL and testbench
=====================================

Name: box_stream_arbiter

Overview:
- Shares one upstream PCIe stream channel (valid/ack, 64-bit) between four result producers, e.g. several box/sobel filter instances inside user_logic.
- Round-robin arbitration, with bursts bounded at BURST_LEN beats per grant.
- Zero-latency data path while granted.
- Per-source beat counters, readable through a select input, for the user register interface.

Parameters:
- BURST_LEN, 16, maximum beats transferred per grant; legal range 1..255.
- NSRC, 4, number of requesters; fixed at 4 in this revision.

Ports:
- i_clk  input  1  user clock
- i_rst  input  1  asynchronous active-high reset
- i_src_data_valid  input  4  per-source data valid; bit n belongs to source n
- i_src_data  input  256  per-source data; source n occupies bits [64n+63:64n]
- o_src_ack  output  4  per-source ack; a beat moves when valid and ack are high in the same cycle
- o_data_valid  output  1  upstream data valid
- o_data  output  64  upstream data
- i_data_ack  input  1  upstream ack
- i_enable_mask  input  4  source n may win arbitration only while bit n = 1
- o_grant  output  4  one-hot current grant; all zeros when idle
- i_cnt_sel  input  2  selects which beat counter appears on o_cnt
- i_cnt_clr  input  1  synchronous clear of all beat counters
- o_cnt  output  32  beat count of the selected source

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; o_grant = 0; last_grant = 3, so source 0 has first priority.
  - beat_cnt = 0; all four counters = 0.
  - Outputs during reset: o_data_valid = 0, o_src_ack = 0, o_cnt = 0. o_data is don't-care, but drive it to 0 when idle.
- FSM states: IDLE and BURST.
- IDLE:
  - req = i_src_data_valid & i_enable_mask.
  - If req != 0, pick the first set bit searching from last_grant+1 upward, mod 4.
  - Register that bit into o_grant and into last_grant, clear beat_cnt, go to BURST.
  - If req == 0, stay in IDLE.
  - Arbitration always costs exactly one cycle; no data moves in IDLE.
- BURST, with g = granted index (all combinational):
  - o_data_valid = i_src_data_valid[g]
  - o_data = i_src_data[g]
  - o_src_ack[g] = i_data_ack; all other ack bits = 0.
  - xfer = o_data_valid & i_data_ack.
- BURST counting and release:
  - On xfer, beat_cnt increments.
  - If xfer occurs with beat_cnt == BURST_LEN-1, go to IDLE and clear o_grant at the next edge.
  - If i_src_data_valid[g] == 0 at a clock edge, go to IDLE; the source released early.
  - Upstream stall (i_data_ack low) never releases the grant and never advances beat_cnt.
- Mask and gaps:
  - Clearing i_enable_mask[g] mid-burst does not revoke the grant. The mask gates only new grants.
  - There is always at least one idle cycle between consecutive grants, including re-grant of the same source.
- Fairness: after a grant to source n, the next grant goes to the lowest-rotation requester after n. A continuously requesting source is served at least once per 4 grants.
- Beat counters:
  - Four 32-bit counters; counter n increments on each xfer while g == n.
  - They wrap from 0xFFFFFFFF to 0 with no saturation.
  - i_cnt_clr clears all four and takes priority over a same-cycle increment.
  - o_cnt = counter[i_cnt_sel], combinational.
- Reset mid-burst: the grant drops immediately (async). Any beat that is in flight but not yet acked is not counted and must be re-presented by its source.
- BURST_LEN = 1: every beat is followed by an idle arbitration cycle.

Test Plan:
- Single source: source 2 valid with 40 beats, upstream ack tied high, BURST_LEN = 16. Expect grants of 16, 16 and 8 beats, one idle cycle between grants, data in order, counter 2 = 40.
- All four sources valid continuously, ack high. Expect grant order 0,1,2,3,0,…; each grant is exactly 16 beats; after 8 grants every counter = 32.
- Source 1 granted, upstream ack held low for 10 cycles mid-burst. Expect o_data_valid to stay 1, o_data to stay stable, beat_cnt frozen, grant retained, and no beats lost once ack returns.
- Source 0 drops valid after 5 beats:
  - Expect release at the next edge and counter 0 = 5.
  - Expect source 3, also requesting, to be granted after one idle cycle.
  - Then expect source 0 to be re-granted only after source 3, when it re-asserts.
- i_enable_mask = 4'b1010 with all sources valid. Expect only sources 1 and 3 to alternate. Clearing bit 1 mid-burst lets that burst complete at 16 beats.
- Assert i_rst mid-burst (beat 7). Expect o_grant = 0, o_data_valid = 0 and o_cnt = 0 immediately. After release, the first grant goes to source 0 if it is requesting.

Source files
------------

// File: rtl/box_stream_arbiter.sv
// box_stream_arbiter
//   Shares one upstream valid/ack stream channel between four producers using
//   round-robin arbitration. Each grant allows at most BURST_LEN beats. While a
//   source is granted, its data path is connected combinationally to the
//   upstream port. Per-source 32-bit beat counters can be read through a select
//   input.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_src_data_valid   per-source valid (bit n = source n)
//   i_src_data         per-source data, source n at [64n+63:64n]
//   o_src_ack          per-source ack
//   o_data_valid       upstream valid
//   o_data             upstream data
//   i_data_ack         upstream ack
//   i_enable_mask      gates new grants per source
//   o_grant            one-hot current grant, zero when idle
//   i_cnt_sel          beat counter select
//   i_cnt_clr          synchronous clear of all beat counters
//   o_cnt              selected beat counter
module box_stream_arbiter #(
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned NSRC      = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NSRC-1:0]      i_src_data_valid,
   input  logic [NSRC*64-1:0]   i_src_data,
   output logic [NSRC-1:0]      o_src_ack,
   output logic                 o_data_valid,
   output logic [63:0]          o_data,
   input  logic                 i_data_ack,
   input  logic [NSRC-1:0]      i_enable_mask,
   output logic [NSRC-1:0]      o_grant,
   input  logic [1:0]           i_cnt_sel,
   input  logic                 i_cnt_clr,
   output logic [31:0]          o_cnt
);

   localparam logic [7:0] BeatLast = 8'(BURST_LEN - 1);

   typedef enum logic {StIdle, StBurst} state_e;

   state_e      state_q, state_d;
   logic [3:0]  grant_q, grant_d;
   logic [1:0]  last_q, last_d;
   logic [7:0]  beat_q, beat_d;
   logic [31:0] cnt_q [NSRC];
   logic [31:0] cnt_d [NSRC];

   logic [3:0]  req;
   logic [1:0]  cand;
   logic [1:0]  pick;
   logic        pick_vld;
   logic [1:0]  g;
   logic        data_valid;
   logic        xfer;

   // last_q holds the granted index for the whole burst.
   assign g = last_q;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      req      = i_src_data_valid & i_enable_mask;
      cand     = '0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!pick_vld && req[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   // Zero-latency data path while granted.
   always_comb begin
      data_valid = 1'b0;
      o_data     = '0;
      o_src_ack  = '0;
      if (state_q == StBurst) begin
         data_valid   = i_src_data_valid[g];
         o_data       = i_src_data[{g, 6'd0} +: 64];
         o_src_ack[g] = i_data_ack;
      end
      xfer = data_valid & i_data_ack;
   end

   assign o_data_valid = data_valid;
   assign o_grant      = grant_q;
   assign o_cnt        = cnt_q[i_cnt_sel];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      beat_d  = beat_q;
      unique case (state_q)
         StIdle: begin
            if (pick_vld) begin
               state_d = StBurst;
               grant_d = 4'b0001 << pick;
               last_d  = pick;
               beat_d  = '0;
            end
         end
         StBurst: begin
            if (xfer) begin
               beat_d = beat_q + 8'd1;
            end
            // Release on early valid drop or on the final beat of the burst.
            if (!i_src_data_valid[g] || (xfer && beat_q == BeatLast)) begin
               state_d = StIdle;
               grant_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Clear wins over a same-cycle increment.
   always_comb begin
      for (int n = 0; n < NSRC; n++) begin
         cnt_d[n] = cnt_q[n];
         if (i_cnt_clr) begin
            cnt_d[n] = '0;
         end else if (xfer && g == 2'(n)) begin
            cnt_d[n] = cnt_q[n] + 32'd1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         grant_q <= '0;
         last_q  <= 2'd3;
         beat_q  <= '0;
         for (int n = 0; n < NSRC; n++) begin
            cnt_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         for (int n = 0; n < NSRC; n++) begin
            cnt_q[n] <= cnt_d[n];
         end
      end
   end

endmodule

// File: tb/tb_box_stream_arbiter.sv
// Bench for box_stream_arbiter: directed vector table, hand-written multi-cycle
// sequences and a randomized run, all checked against a transaction-level
// reference model (owner index, beats taken, per-source totals).
module tb_box_stream_arbiter;

   localparam int BURST_LEN = 16;

   logic          i_clk;
   logic          i_rst;
   logic [3:0]    i_src_data_valid;
   logic [255:0]  i_src_data;
   logic [3:0]    o_src_ack;
   logic          o_data_valid;
   logic [63:0]   o_data;
   logic          i_data_ack;
   logic [3:0]    i_enable_mask;
   logic [3:0]    o_grant;
   logic [1:0]    i_cnt_sel;
   logic          i_cnt_clr;
   logic [31:0]   o_cnt;

   box_stream_arbiter #(.BURST_LEN(BURST_LEN), .NSRC(4)) dut (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_src_data_valid (i_src_data_valid),
      .i_src_data       (i_src_data),
      .o_src_ack        (o_src_ack),
      .o_data_valid     (o_data_valid),
      .o_data           (o_data),
      .i_data_ack       (i_data_ack),
      .i_enable_mask    (i_enable_mask),
      .o_grant          (o_grant),
      .i_cnt_sel        (i_cnt_sel),
      .i_cnt_clr        (i_cnt_clr),
      .o_cnt            (o_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: who owns the channel, how many beats it has taken, totals.
   int          m_owner;
   int          m_last;
   int          m_beats;
   logic [31:0] m_cnt [4];

   task automatic model_reset();
      m_owner = -1;
      m_last  = 3;
      m_beats = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
   endtask

   task automatic model_step();
      logic [3:0] req;
      int pick;
      bit xf;
      if (m_owner < 0) begin
         req  = i_src_data_valid & i_enable_mask;
         pick = -1;
         for (int k = 1; k <= 4; k++)
            if (pick < 0 && req[(m_last + k) % 4]) pick = (m_last + k) % 4;
         if (pick >= 0) begin
            m_owner = pick;
            m_last  = pick;
            m_beats = 0;
         end
      end else begin
         xf = i_src_data_valid[m_owner] && i_data_ack;
         if (xf) begin
            m_cnt[m_owner] = m_cnt[m_owner] + 1;
            m_beats++;
         end
         if (!i_src_data_valid[m_owner]) m_owner = -1;
         else if (xf && m_beats == BURST_LEN) m_owner = -1;
      end
      if (i_cnt_clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
   endtask

   // Compare DUT outputs against the model mid-cycle.
   task automatic sample();
      logic [3:0]  e_grant, e_ack;
      logic        e_dv;
      logic [63:0] e_data;
      @(negedge i_clk);
      e_grant = 0; e_ack = 0; e_dv = 0; e_data = 0;
      if (m_owner >= 0) begin
         e_grant = 4'b0001 << m_owner;
         e_ack   = i_data_ack ? e_grant : 4'b0000;
         e_dv    = i_src_data_valid[m_owner];
         e_data  = i_src_data[m_owner*64 +: 64];
      end
      chk("model_grant", 64'(o_grant), 64'(e_grant));
      chk("model_src_ack", 64'(o_src_ack), 64'(e_ack));
      chk("model_data_valid", 64'(o_data_valid), 64'(e_dv));
      chk("model_data", o_data, e_data);
      chk("model_cnt", 64'(o_cnt), 64'(m_cnt[i_cnt_sel]));
   endtask

   task automatic advance();
      @(posedge i_clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      model_reset();
      #1;
      chk("reset_grant", 64'(o_grant), 64'd0);
      chk("reset_data_valid", 64'(o_data_valid), 64'd0);
      chk("reset_src_ack", 64'(o_src_ack), 64'd0);
      chk("reset_cnt", 64'(o_cnt), 64'd0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  mask;
      logic        ack;
      logic        clr;
      logic [1:0]  sel;
      logic [3:0]  e_grant;
      logic        e_dv;
      logic [3:0]  e_sack;
      logic [63:0] e_data;
      logic [31:0] e_cnt;
   } vec_t;

   localparam logic [63:0] D0 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] D2 = 64'h3333_3333_3333_3333;

   vec_t tbl [11];
   int   runs [$];
   int   order [$];

   initial begin
      logic [3:0] v;
      logic [3:0] prev;
      int k, cur, nx;
      bit xf;

      tbl[0]  = '{4'b0000, 4'hF, 1, 0, 2'd0, 4'b0000, 0, 4'b0000, 64'd0, 32'd0};
      tbl[1]  = '{4'b0100, 4'hF, 1, 0, 2'd2, 4'b0000, 0, 4'b0000, 64'd0, 32'd0};
      tbl[2]  = '{4'b0100, 4'hF, 1, 0, 2'd2, 4'b0100, 1, 4'b0100, D2,    32'd0};
      tbl[3]  = '{4'b0100, 4'hF, 1, 0, 2'd2, 4'b0100, 1, 4'b0100, D2,    32'd1};
      tbl[4]  = '{4'b0100, 4'hF, 0, 0, 2'd2, 4'b0100, 1, 4'b0000, D2,    32'd2};
      tbl[5]  = '{4'b0000, 4'hF, 1, 0, 2'd2, 4'b0100, 0, 4'b0100, D2,    32'd2};
      tbl[6]  = '{4'b1111, 4'h5, 1, 0, 2'd2, 4'b0000, 0, 4'b0000, 64'd0, 32'd2};
      tbl[7]  = '{4'b1111, 4'h5, 1, 0, 2'd0, 4'b0001, 1, 4'b0001, D0,    32'd0};
      tbl[8]  = '{4'b1111, 4'h5, 1, 1, 2'd2, 4'b0001, 1, 4'b0001, D0,    32'd2};
      tbl[9]  = '{4'b0000, 4'h5, 1, 0, 2'd0, 4'b0001, 0, 4'b0001, D0,    32'd0};
      tbl[10] = '{4'b0000, 4'hF, 1, 0, 2'd2, 4'b0000, 0, 4'b0000, 64'd0, 32'd0};

      i_src_data_valid = 0;
      i_src_data       = {64'h4444_4444_4444_4444, D2, 64'h2222_2222_2222_2222, D0};
      i_data_ack       = 0;
      i_enable_mask    = 4'hF;
      i_cnt_sel        = 0;
      i_cnt_clr        = 0;
      do_reset();

      // Directed vector table.
      for (int i = 0; i < 11; i++) begin
         i_src_data_valid = tbl[i].valid;
         i_enable_mask    = tbl[i].mask;
         i_data_ack       = tbl[i].ack;
         i_cnt_clr        = tbl[i].clr;
         i_cnt_sel        = tbl[i].sel;
         sample();
         chk($sformatf("tbl%0d_grant", i), 64'(o_grant), 64'(tbl[i].e_grant));
         chk($sformatf("tbl%0d_dv", i), 64'(o_data_valid), 64'(tbl[i].e_dv));
         chk($sformatf("tbl%0d_sack", i), 64'(o_src_ack), 64'(tbl[i].e_sack));
         chk($sformatf("tbl%0d_data", i), o_data, tbl[i].e_data);
         chk($sformatf("tbl%0d_cnt", i), 64'(o_cnt), 64'(tbl[i].e_cnt));
         advance();
      end
      i_cnt_clr = 0;

      // Single source, 40 beats: bursts of 16, 16, 8.
      do_reset();
      i_enable_mask = 4'hF;
      i_data_ack    = 1;
      i_cnt_sel     = 2;
      k = 0; cur = 0; prev = 0;
      for (int c = 0; c < 200 && runs.size() < 3; c++) begin
         i_src_data_valid = (k < 40) ? 4'b0100 : 4'b0000;
         i_src_data[128 +: 64] = 64'(k);
         sample();
         xf = o_data_valid & i_data_ack;
         if (xf) chk("single_data_order", o_data, 64'(k));
         if (o_grant != 0) cur += int'(xf);
         else if (prev != 0) begin
            runs.push_back(cur);
            cur = 0;
         end
         prev = o_grant;
         advance();
         if (xf) k++;
      end
      chk("single_run_count", 64'(runs.size()), 64'd3);
      chk("single_run0", 64'(runs.size() > 0 ? runs[0] : -1), 64'd16);
      chk("single_run1", 64'(runs.size() > 1 ? runs[1] : -1), 64'd16);
      chk("single_run2", 64'(runs.size() > 2 ? runs[2] : -1), 64'd8);
      #1;
      chk("single_cnt2", 64'(o_cnt), 64'd40);

      // All four requesting: order 0,1,2,3,... and 32 beats each after 8 grants.
      do_reset();
      i_src_data_valid = 4'hF;
      prev = 0;
      for (int c = 0; c < 8 * (BURST_LEN + 1); c++) begin
         i_src_data = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
         sample();
         if (o_grant != 0 && prev == 0)
            for (int s = 0; s < 4; s++) if (o_grant[s]) order.push_back(s);
         prev = o_grant;
         advance();
      end
      chk("rr_grant_count", 64'(order.size()), 64'd8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("rr_order%0d", i), 64'(order.size() > i ? order[i] : -1), 64'(i % 4));
      for (int s = 0; s < 4; s++) begin
         i_cnt_sel = 2'(s);
         #1;
         chk($sformatf("rr_cnt%0d", s), 64'(o_cnt), 64'd32);
      end

      // Reset mid-burst at beat 7, then source 0 is first again.
      do_reset();
      i_src_data_valid = 4'hF;
      i_data_ack       = 1;
      i_cnt_sel        = 0;
      nx = 0;
      for (int c = 0; c < 50; c++) begin
         sample();
         if (nx == 7) break;
         if (o_data_valid & i_data_ack) nx++;
         advance();
      end
      chk("midrst_beats_before", 64'(nx), 64'd7);
      #2 i_rst = 1'b1;
      #1;
      chk("midrst_grant", 64'(o_grant), 64'd0);
      chk("midrst_data_valid", 64'(o_data_valid), 64'd0);
      chk("midrst_cnt", 64'(o_cnt), 64'd0);
      model_reset();
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      sample();
      advance();
      sample();
      chk("midrst_first_grant", 64'(o_grant), 64'b0001);
      advance();

      // Randomized traffic against the model.
      do_reset();
      v = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int s = 0; s < 4; s++) if ($urandom % 8 == 0) v[s] = ~v[s];
         i_src_data_valid = v;
         if ($urandom % 60 == 0) i_enable_mask = 4'($urandom);
         i_data_ack = ($urandom % 4) != 0;
         i_cnt_clr  = ($urandom % 150) == 0;
         i_cnt_sel  = 2'($urandom);
         i_src_data = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
         sample();
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
